// File: rtl/quadratic_pkg.sv
// Shared widths, FSM encoding and sign-extension helpers for the quadratic
// root search datapath.
package quadratic_pkg;

  localparam int WL_DEF = 15;
  localparam int AW_DEF = 3 * WL_DEF + 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    INIT = 2'd1,
    SCAN = 2'd2,
    DONE = 2'd3
  } state_e;

  function automatic logic signed [AW_DEF-1:0] sext_wl(input logic signed [WL_DEF-1:0] v);
    return AW_DEF'(v);
  endfunction

  function automatic logic signed [AW_DEF-1:0] sext_y(input logic signed [2*WL_DEF-1:0] v);
    return AW_DEF'(v);
  endfunction

endpackage

// File: rtl/quad_init_eval.sv
// Seeds the forward-difference scan: g0 = f(x_lo) - y and d0 = f(x_lo+1) - f(x_lo).
// The only multipliers of the search live here and are consumed during INIT.
module quad_init_eval
  import quadratic_pkg::*;
#(
  parameter int WL = WL_DEF,
  parameter int AW = 3 * WL + 2
) (
  input  logic signed [WL-1:0]   a,
  input  logic signed [WL-1:0]   b,
  input  logic signed [WL-1:0]   c,
  input  logic signed [2*WL-1:0] y,
  input  logic signed [WL-1:0]   x_lo,
  output logic signed [AW-1:0]   g0,
  output logic signed [AW-1:0]   d0
);

  localparam logic signed [AW-1:0] ONE = 1;

  logic signed [AW-1:0] a_e, b_e, c_e, x_e, y_e;

  assign a_e = sext_wl(a);
  assign b_e = sext_wl(b);
  assign c_e = sext_wl(c);
  assign x_e = sext_wl(x_lo);
  assign y_e = sext_y(y);

  assign g0 = a_e * x_e * x_e + b_e * x_e + c_e - y_e;
  assign d0 = a_e * ((x_e <<< 1) + ONE) + b_e;

endmodule

// File: rtl/quadratic_root_search.sv
// Scans x upward from x_lo for the first point where A*x^2+B*x+C meets or
// crosses y, advancing g = f(x)-y with one add per cycle.
module quadratic_root_search
  import quadratic_pkg::*;
#(
  parameter int WL = WL_DEF,
  parameter int AW = 3 * WL + 2
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   start,
  input  logic signed [WL-1:0]   a,
  input  logic signed [WL-1:0]   b,
  input  logic signed [WL-1:0]   c,
  input  logic signed [2*WL-1:0] y,
  input  logic signed [WL-1:0]   x_lo,
  input  logic signed [WL-1:0]   x_hi,
  output logic                   busy,
  output logic                   done,
  output logic                   found,
  output logic                   exact,
  output logic signed [WL-1:0]   x_out,
  output logic signed [AW-1:0]   f_out
);

  localparam logic signed [WL-1:0] X_ONE = 1;

  state_e state_q, state_d;
  logic signed [WL-1:0]   a_q, a_d, b_q, b_d, c_q, c_d;
  logic signed [2*WL-1:0] y_q, y_d;
  logic signed [WL-1:0]   xlo_q, xlo_d, xhi_q, xhi_d;
  logic signed [WL-1:0]   x_q, x_d;
  logic signed [AW-1:0]   g_q, g_d, d_q, d_d, gp_q, gp_d;
  logic                   pv_q, pv_d;
  logic                   found_q, found_d, exact_q, exact_d;
  logic signed [WL-1:0]   xout_q, xout_d;
  logic signed [AW-1:0]   fout_q, fout_d;

  logic signed [AW-1:0] g0, d0, y_e, a_e;
  logic hit_exact, hit_cross, at_end;

  quad_init_eval #(.WL(WL), .AW(AW)) u_init (
    .a    (a_q),
    .b    (b_q),
    .c    (c_q),
    .y    (y_q),
    .x_lo (xlo_q),
    .g0   (g0),
    .d0   (d0)
  );

  assign y_e = sext_y(y_q);
  assign a_e = sext_wl(a_q);

  // g_prev is never zero when pv_q is set (a zero would already have hit),
  // so comparing sign bits is a true sign-change test.
  assign hit_exact = (g_q == '0);
  assign hit_cross = pv_q && (g_q[AW-1] != gp_q[AW-1]);
  assign at_end    = (x_q == xhi_q);

  always_comb begin
    state_d = state_q;
    a_d = a_q; b_d = b_q; c_d = c_q; y_d = y_q;
    xlo_d = xlo_q; xhi_d = xhi_q;
    x_d = x_q; g_d = g_q; d_d = d_q; gp_d = gp_q; pv_d = pv_q;
    found_d = found_q; exact_d = exact_q; xout_d = xout_q; fout_d = fout_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          a_d = a; b_d = b; c_d = c; y_d = y;
          xlo_d = x_lo; xhi_d = x_hi;
          found_d = 1'b0; exact_d = 1'b0; xout_d = '0; fout_d = '0;
          state_d = INIT;
        end
      end
      INIT: begin
        if (xlo_q > xhi_q) begin
          xout_d  = xlo_q;
          fout_d  = g0 + y_e;
          state_d = DONE;
        end else begin
          x_d = xlo_q; g_d = g0; d_d = d0; pv_d = 1'b0;
          state_d = SCAN;
        end
      end
      SCAN: begin
        // Bound test precedes the increment, so x never wraps past x_hi.
        if (hit_exact || hit_cross || at_end) begin
          found_d = hit_exact || hit_cross;
          exact_d = hit_exact;
          xout_d  = x_q;
          fout_d  = g_q + y_e;
          state_d = DONE;
        end else begin
          gp_d = g_q;
          pv_d = 1'b1;
          x_d  = x_q + X_ONE;
          g_d  = g_q + d_q;
          d_d  = d_q + (a_e <<< 1);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      a_q <= '0; b_q <= '0; c_q <= '0; y_q <= '0;
      xlo_q <= '0; xhi_q <= '0;
      x_q <= '0; g_q <= '0; d_q <= '0; gp_q <= '0; pv_q <= 1'b0;
      found_q <= 1'b0; exact_q <= 1'b0; xout_q <= '0; fout_q <= '0;
    end else begin
      state_q <= state_d;
      a_q <= a_d; b_q <= b_d; c_q <= c_d; y_q <= y_d;
      xlo_q <= xlo_d; xhi_q <= xhi_d;
      x_q <= x_d; g_q <= g_d; d_q <= d_d; gp_q <= gp_d; pv_q <= pv_d;
      found_q <= found_d; exact_q <= exact_d; xout_q <= xout_d; fout_q <= fout_d;
    end
  end

  assign busy  = (state_q == INIT) || (state_q == SCAN);
  assign done  = (state_q == DONE);
  assign found = found_q;
  assign exact = exact_q;
  assign x_out = xout_q;
  assign f_out = fout_q;

endmodule

// File: doc/quadratic_root_search.md
# quadratic_root_search

- Iterative inverse of the quadratic evaluator.
- Given signed coefficients A, B, C, a target value y and an integer range [x_lo, x_hi], the block scans x upward from x_lo. It returns the first integer x where f(x) = A·x² + B·x + C equals y or crosses it.
- The scan uses forward differences: one add per cycle, multipliers used only at initialisation.
- Sits beside the quadratic evaluator in the datapath and is driven by a start/done handshake.

## Interface

Parameters:
- WL, 15, width of x, A, B, C (signed).
- AW, 3*WL+2, internal accumulator width (derived; do not override).

Ports:
- CLK  in  1  rising-edge clock.
- RST  in  1  synchronous, active-high reset.
- start  in  1  request pulse; sampled only in IDLE.
- a, b, c  in  WL each  signed coefficients A, B, C.
- y  in  2*WL  signed target, sign-extended to AW.
- x_lo, x_hi  in  WL each  signed inclusive search bounds.
- busy  out  1  high in INIT and SCAN.
- done  out  1  one-cycle pulse when the result is valid.
- found  out  1  a hit was located.
- exact  out  1  the hit is an exact equality (f(x) = y).
- x_out  out  WL  hit x, or last x examined on a miss.
- f_out  out  AW  f(x_out), signed.

## Operation

- Define g(x) = f(x) − y.
- FSM has four states: IDLE, INIT, SCAN, DONE.
- IDLE:
  - start=1 latches a, b, c, y, x_lo, x_hi and moves to INIT.
  - start=0 stays in IDLE.
- INIT:
  - If x_lo > x_hi: go to DONE with found=0, exact=0, x_out=x_lo, f_out=f(x_lo).
  - Otherwise load x=x_lo, g=g(x_lo), d=A·(2·x_lo+1)+B and clear the prev-valid flag; go to SCAN.
- SCAN, one x per cycle, in this priority:
  - g==0 → hit, exact=1.
  - Else prev-valid and sign(g) ≠ sign(g_prev) → hit, exact=0. The crossing x is reported (the first x past the crossing).
  - Else x==x_hi → miss, found=0.
  - Else update: g_prev←g, prev-valid←1, x←x+1, g←g+d, d←d+2A.
- On a hit or miss, register x_out=x and f_out=g+y, set found, and go to DONE.
- At x_lo there is no previous sample, so only an exact hit is possible there.
- DONE: assert done for one cycle, then return to IDLE.
- found, exact, x_out and f_out hold until the next accepted start clears them (cleared on entry to INIT).
- Arithmetic:
  - All internal math is signed at AW bits, with inputs sign-extended before use.
  - No overflow is possible within AW for WL-bit operands.
- A=0 is legal (linear scan); d is then constant.

## Timing

- Reset: state=IDLE; busy, done, found, exact = 0; x_out = 0; f_out = 0.
- start sampled high in cycle 0:
  - Cycle 1 is INIT.
  - SCAN examines x_lo+k in cycle 2+k.
  - done is high in cycle 3+k.
- Empty range (x_lo > x_hi): done in cycle 2.
- Miss: done in cycle 3+(x_hi−x_lo).
- Worst-case latency: 2^WL + 2 cycles.
- busy is high in cycles 1 through 2+k and low in the done cycle.
- start while busy or in DONE is ignored; it is not queued.
- x never increments past x_hi. With x_hi = 2^(WL−1)−1 there is no wrap, because the bound test precedes the increment.
- RST has priority over everything. Asserting it mid-scan returns to IDLE on the next edge with all outputs at reset values and no done pulse.

## Structure

- Package quadratic_pkg:
  - WL default.
  - AW derivation.
  - FSM state enumeration (IDLE, INIT, SCAN, DONE).
  - Sign-extension helper function.
- Sub-module quad_init_eval (combinational):
  - Inputs: a, b, c, y, x_lo.
  - Outputs: g0 and d0 at AW bits.
  - Holds the only multipliers in the block; used in INIT only.
- Top level holds the FSM, the latched operands, and the x, g, d, g_prev registers.

## Test plan

- a=−4, b=3, c=−3, y=−13, range [0,5]:
  - g = 10, 9, 0.
  - Expect found=1, exact=1, x_out=2, f_out=−13, done in cycle 5.
- a=−4, b=3, c=−3, y=0, range [−5,5]:
  - f stays negative everywhere.
  - Expect found=0, x_out=5, f_out=−88, done in cycle 13.
- a=1, b=0, c=0, y=10, range [0,10]:
  - Sign change between x=3 and x=4.
  - Expect found=1, exact=0, x_out=4, f_out=16, done in cycle 7.
- x_lo=3, x_hi=2 (empty range):
  - Expect done in cycle 2, found=0, x_out=3, busy high only in cycle 1.
- Pulse start again in cycles 2–4 during the first scenario:
  - The result is unchanged and exactly one done pulse occurs.
- RST asserted in cycle 4 of the second scenario:
  - From cycle 5: IDLE, all outputs 0, no done.
  - A new start is accepted in cycle 6.
